imul_arb_ctrl: RTL and testbench



---
 rtl/imul_arb_ctrl_if.sv | 47 ++++
 rtl/imul_arb_ctrl.sv | 103 ++++++++++
 tb/tb_imul_arb_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imul_arb_ctrl_if.sv
// Bundles the two requester channels and the multiplier-unit channel of the
// arbitration controller into one val/rdy interface.
interface imul_arb_ctrl_if #(
    parameter int p_req_nbits  = 64,
    parameter int p_resp_nbits = 32
);
    logic                    req0_val;
    logic                    req0_rdy;
    logic [p_req_nbits-1:0]  req0_msg;
    logic                    req1_val;
    logic                    req1_rdy;
    logic [p_req_nbits-1:0]  req1_msg;

    logic                    resp0_val;
    logic                    resp0_rdy;
    logic [p_resp_nbits-1:0] resp0_msg;
    logic                    resp1_val;
    logic                    resp1_rdy;
    logic [p_resp_nbits-1:0] resp1_msg;

    logic                    unit_req_val;
    logic                    unit_req_rdy;
    logic [p_req_nbits-1:0]  unit_req_msg;
    logic                    unit_resp_val;
    logic                    unit_resp_rdy;
    logic [p_resp_nbits-1:0] unit_resp_msg;

    // master: the controller itself
    modport master (
        input  req0_val, req0_msg, req1_val, req1_msg,
        input  resp0_rdy, resp1_rdy,
        input  unit_req_rdy, unit_resp_val, unit_resp_msg,
        output req0_rdy, req1_rdy,
        output resp0_val, resp0_msg, resp1_val, resp1_msg,
        output unit_req_val, unit_req_msg, unit_resp_rdy
    );

    // slave: requesters plus multiplier unit surrounding the controller
    modport slave (
        output req0_val, req0_msg, req1_val, req1_msg,
        output resp0_rdy, resp1_rdy,
        output unit_req_rdy, unit_resp_val, unit_resp_msg,
        input  req0_rdy, req1_rdy,
        input  resp0_val, resp0_msg, resp1_val, resp1_msg,
        input  unit_req_val, unit_req_msg, unit_resp_rdy
    );
endinterface

// File: rtl/imul_arb_ctrl.sv
// Round-robin arbiter that shares one iterative multiplier between two
// requesters: accept one request, issue it, route the product back to its owner.
module imul_arb_ctrl #(
    parameter int p_req_nbits  = 64,
    parameter int p_resp_nbits = 32
) (
    input  logic             clk,
    input  logic             reset,
    imul_arb_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   prio_q, prio_d;
    logic                   owner_q, owner_d;
    logic [p_req_nbits-1:0] msg_q;

    logic                   grant;
    logic                   accept;
    logic                   owner_resp_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
        end
    end

    // Operand register has no reset: it is only observed after being loaded.
    always_ff @(posedge clk) begin
        if (accept) begin
            msg_q <= grant ? bus.req1_msg : bus.req0_msg;
        end
    end

    always_comb begin
        state_d        = state_q;
        prio_d         = prio_q;
        owner_d        = owner_q;
        accept         = 1'b0;
        grant          = (bus.req0_val && bus.req1_val) ? prio_q : bus.req1_val;
        owner_resp_rdy = owner_q ? bus.resp1_rdy : bus.resp0_rdy;

        bus.req0_rdy      = 1'b0;
        bus.req1_rdy      = 1'b0;
        bus.resp0_val     = 1'b0;
        bus.resp1_val     = 1'b0;
        bus.unit_req_val  = 1'b0;
        bus.unit_resp_rdy = 1'b0;
        bus.unit_req_msg  = msg_q;
        bus.resp0_msg     = bus.unit_resp_msg;
        bus.resp1_msg     = bus.unit_resp_msg;

        // Handshake outputs stay quiet for the whole time reset is high.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    bus.req0_rdy = bus.req0_val && !grant;
                    bus.req1_rdy = bus.req1_val && grant;
                    if (bus.req0_val || bus.req1_val) begin
                        accept  = 1'b1;
                        owner_d = grant;
                        prio_d  = ~grant;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    bus.unit_req_val = 1'b1;
                    if (bus.unit_req_rdy) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    bus.resp0_val     = bus.unit_resp_val && !owner_q;
                    bus.resp1_val     = bus.unit_resp_val && owner_q;
                    bus.unit_resp_rdy = owner_resp_rdy;
                    if (bus.unit_resp_val && owner_resp_rdy) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    a_unit_req_rdy_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown(bus.unit_req_rdy));
    a_unit_resp_val_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown(bus.unit_resp_val));
    a_req_val_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown({bus.req0_val, bus.req1_val}));

endmodule

// File: tb/tb_imul_arb_ctrl.sv
// Directed bench for imul_arb_ctrl: a transaction-level model checks every
// output on every cycle, and literal expectations pin the model per scenario.
module tb_imul_arb_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   unit_lat;

    imul_arb_ctrl_if #(.p_req_nbits(64), .p_resp_nbits(32)) bus ();

    imul_arb_ctrl #(.p_req_nbits(64), .p_resp_nbits(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int          grant_log[$];
    logic [31:0] r0_log[$];
    logic [31:0] r1_log[$];

    // transaction-level model: one transaction in flight, issued or not yet
    bit          m_busy;
    bit          m_issued;
    bit          m_owner;
    bit          m_prio;
    logic [63:0] m_msg;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] op(input int a, input int b);
        logic [31:0] aa;
        logic [31:0] bb;
        aa = a;
        bb = b;
        return {aa, bb};
    endfunction

    // per-cycle model compare
    always @(negedge clk) begin
        logic e_r0, e_r1, e_uv, e_urr, e_rv0, e_rv1;
        bit   g;
        e_r0 = 0; e_r1 = 0; e_uv = 0; e_urr = 0; e_rv0 = 0; e_rv1 = 0;
        g = 0;
        if (reset) begin
            m_busy = 0;
            m_prio = 0;
        end else if (!m_busy) begin
            if (bus.req0_val || bus.req1_val) begin
                g = (bus.req0_val && bus.req1_val) ? m_prio : bus.req1_val;
                e_r0 = bus.req0_val && !g;
                e_r1 = bus.req1_val && g;
                m_busy   = 1;
                m_issued = 0;
                m_owner  = g;
                m_msg    = g ? bus.req1_msg : bus.req0_msg;
                m_prio   = !g;
                grant_log.push_back(int'(g));
            end
        end else if (!m_issued) begin
            e_uv = 1;
            chk("unit_req_msg", bus.unit_req_msg, m_msg);
            if (bus.unit_req_rdy) m_issued = 1;
        end else begin
            e_rv0 = bus.unit_resp_val && !m_owner;
            e_rv1 = bus.unit_resp_val && m_owner;
            e_urr = m_owner ? bus.resp1_rdy : bus.resp0_rdy;
            if (e_rv0) chk("resp0_msg", {32'd0, bus.resp0_msg}, {32'd0, bus.unit_resp_msg});
            if (e_rv1) chk("resp1_msg", {32'd0, bus.resp1_msg}, {32'd0, bus.unit_resp_msg});
            if (bus.unit_resp_val && e_urr) begin
                $display("txn: req%0d %0d*%0d -> %0d", m_owner, m_msg[63:32], m_msg[31:0],
                         bus.unit_resp_msg);
                if (m_owner) r1_log.push_back(bus.unit_resp_msg);
                else         r0_log.push_back(bus.unit_resp_msg);
                m_busy = 0;
            end
        end
        chk("req0_rdy", bus.req0_rdy, e_r0);
        chk("req1_rdy", bus.req1_rdy, e_r1);
        chk("unit_req_val", bus.unit_req_val, e_uv);
        chk("unit_resp_rdy", bus.unit_resp_rdy, e_urr);
        chk("resp0_val", bus.resp0_val, e_rv0);
        chk("resp1_val", bus.resp1_val, e_rv1);
    end

    // requester drivers: hold val/msg until accepted, then present next queued item
    initial begin
        bit a0, a1;
        forever begin
            @(negedge clk);
            a0 = bus.req0_val && bus.req0_rdy;
            a1 = bus.req1_val && bus.req1_rdy;
            @(posedge clk);
            #2;
            if (a0 && q0.size() != 0) void'(q0.pop_front());
            if (a1 && q1.size() != 0) void'(q1.pop_front());
            bus.req0_val = (q0.size() != 0);
            bus.req1_val = (q1.size() != 0);
            if (q0.size() != 0) bus.req0_msg = q0[0];
            if (q1.size() != 0) bus.req1_msg = q1[0];
        end
    end

    // multiplier unit: fixed latency after accepting operands, holds response until taken
    initial begin
        int          cnt;
        logic [31:0] prod;
        logic [63:0] cap;
        bit          rq, rs, rst;
        cnt = 0;
        prod = 0;
        forever begin
            @(negedge clk);
            rst = reset;
            rq  = bus.unit_req_val && bus.unit_req_rdy;
            rs  = bus.unit_resp_val && bus.unit_resp_rdy;
            cap = bus.unit_req_msg;
            @(posedge clk);
            #1;
            if (rst) begin
                cnt = 0;
                bus.unit_resp_val = 0;
            end else begin
                if (rs) bus.unit_resp_val = 0;
                if (rq) begin
                    cnt  = unit_lat;
                    prod = cap[63:32] * cap[31:0];
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.unit_resp_val = 1;
                        bus.unit_resp_msg = prod;
                    end
                end
            end
        end
    end

    task automatic wait_done(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!m_busy && q0.size() == 0 && q1.size() == 0 && !bus.req0_val && !bus.req1_val) begin
                ok = 1;
                break;
            end
        end
        chk(nm, ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        grant_log.delete();
        r0_log.delete();
        r1_log.delete();
        bus.unit_req_rdy = 1;
        bus.resp0_rdy = 1;
        bus.resp1_rdy = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        n_checks = 0;
        n_errors = 0;
        unit_lat = 4;
        reset = 1;
        bus.req0_val = 0; bus.req0_msg = 0;
        bus.req1_val = 0; bus.req1_msg = 0;
        bus.resp0_rdy = 1; bus.resp1_rdy = 1;
        bus.unit_req_rdy = 1;
        bus.unit_resp_val = 0; bus.unit_resp_msg = 0;

        // T1: req0 held during reset, granted in first cycle after release
        q0.push_back(op(3, 5));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t1_rst_req0_rdy", bus.req0_rdy, 0);
        chk("t1_rst_unit_req_val", bus.unit_req_val, 0);
        @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("t1_req0_rdy", bus.req0_rdy, 1);
        @(negedge clk);
        chk("t1_unit_req_val", bus.unit_req_val, 1);
        chk("t1_unit_req_msg", bus.unit_req_msg, op(3, 5));
        wait_done("t1_done");
        chk("t1_resp0_cnt", r0_log.size(), 1);
        chk("t1_resp0_msg", r0_log[0], 15);
        chk("t1_resp1_cnt", r1_log.size(), 0);

        // T2: both valid from reset
        do_reset();
        q0.push_back(op(2, 7));
        q1.push_back(op(6, 9));
        wait_done("t2_done");
        chk("t2_grant0", grant_log[0], 0);
        chk("t2_grant1", grant_log[1], 1);
        chk("t2_resp0", r0_log[0], 14);
        chk("t2_resp1", r1_log[0], 54);
        chk("t2_prio_end", dut.prio_q, 0);

        // T3: continuous contention for six transactions
        do_reset();
        q0.push_back(op(1, 2));  q0.push_back(op(3, 4));   q0.push_back(op(5, 6));
        q1.push_back(op(7, 8));  q1.push_back(op(9, 10));  q1.push_back(op(11, 12));
        wait_done("t3_done");
        chk("t3_ngrants", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), grant_log[i], i % 2);
        chk("t3_r0_a", r0_log[0], 2);
        chk("t3_r0_b", r0_log[1], 12);
        chk("t3_r0_c", r0_log[2], 30);
        chk("t3_r1_a", r1_log[0], 56);
        chk("t3_r1_b", r1_log[1], 90);
        chk("t3_r1_c", r1_log[2], 132);

        // T4: unit back-pressure while ISSUE
        do_reset();
        bus.unit_req_rdy = 0;
        q0.push_back(op(4, 4));
        @(negedge clk);
        chk("t4_req0_rdy", bus.req0_rdy, 1);
        @(posedge clk);
        #1;
        q1.push_back(op(1, 9));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_unit_req_val", bus.unit_req_val, 1);
            chk("t4_unit_req_msg", bus.unit_req_msg, op(4, 4));
            chk("t4_req0_rdy_low", bus.req0_rdy, 0);
            chk("t4_req1_rdy_low", bus.req1_rdy, 0);
        end
        @(posedge clk);
        #1;
        bus.unit_req_rdy = 1;
        @(negedge clk);
        chk("t4_issue_last", bus.unit_req_val, 1);
        @(negedge clk);
        chk("t4_in_wait", bus.unit_req_val, 0);
        wait_done("t4_done");
        chk("t4_resp0", r0_log[0], 16);
        chk("t4_resp1", r1_log[0], 9);

        // T5: owner back-pressure on response
        do_reset();
        bus.resp1_rdy = 0;
        q1.push_back(op(6, 7));
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.unit_resp_val) begin
                ok = 1;
                break;
            end
        end
        chk("t5_resp_seen", ok, 1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("t5_resp1_val", bus.resp1_val, 1);
            chk("t5_resp1_msg", bus.resp1_msg, 42);
            chk("t5_unit_resp_rdy", bus.unit_resp_rdy, 0);
            chk("t5_resp0_val", bus.resp0_val, 0);
        end
        @(posedge clk);
        #1;
        bus.resp1_rdy = 1;
        @(negedge clk);
        chk("t5_unit_resp_rdy_up", bus.unit_resp_rdy, 1);
        wait_done("t5_done");
        chk("t5_resp1_cnt", r1_log.size(), 1);
        chk("t5_resp1", r1_log[0], 42);

        // T6: reset while waiting for the unit
        do_reset();
        q0.push_back(op(3, 3));
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_busy && m_issued) begin
                ok = 1;
                break;
            end
        end
        chk("t6_reached_wait", ok, 1);
        @(posedge clk);
        #1;
        reset = 1;
        @(negedge clk);
        chk("t6_rst_unit_resp_rdy", bus.unit_resp_rdy, 0);
        @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("t6_req0_rdy", bus.req0_rdy, 0);
        chk("t6_req1_rdy", bus.req1_rdy, 0);
        chk("t6_unit_req_val", bus.unit_req_val, 0);
        chk("t6_unit_resp_rdy", bus.unit_resp_rdy, 0);
        chk("t6_resp0_val", bus.resp0_val, 0);
        chk("t6_resp1_val", bus.resp1_val, 0);
        @(posedge clk);
        #1;
        q1.push_back(op(5, 5));
        @(negedge clk);
        chk("t6_req1_rdy_grant", bus.req1_rdy, 1);
        wait_done("t6_done");
        chk("t6_resp1", r1_log[0], 25);
        chk("t6_resp0_dropped", r0_log.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
